// File: rtl/mem_access_controller_if.sv
// Pipeline-side request/response and data-memory port bundle
// for the MEM-stage access controller.
interface mem_access_controller_if;
  logic        Req;
  logic [2:0]  Op;
  logic [31:0] Addr;
  logic [31:0] StoreData;
  logic        Ready;
  logic        Done;
  logic [31:0] LoadData;
  logic        AddrError;
  logic        BusError;
  logic [31:0] MemAddress;
  logic [31:0] MemWriteData;
  logic        MemWriteEnable;
  logic        MemReadEnable;
  logic [3:0]  MemByteEnable;
  logic        MemAck;
  logic [31:0] MemReadData;

  modport master (
    output Req, Op, Addr, StoreData,
    output MemAck, MemReadData,
    input  Ready, Done, LoadData,
    input  AddrError, BusError,
    input  MemAddress, MemWriteData,
    input  MemWriteEnable, MemReadEnable,
    input  MemByteEnable
  );

  modport slave (
    input  Req, Op, Addr, StoreData,
    input  MemAck, MemReadData,
    output Ready, Done, LoadData,
    output AddrError, BusError,
    output MemAddress, MemWriteData,
    output MemWriteEnable, MemReadEnable,
    output MemByteEnable
  );
endinterface

// File: rtl/mem_access_controller.sv
// MEM-stage load/store sequencer for a word-wide big-endian
// data memory port with alignment and timeout reporting.
module mem_access_controller #(
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 4
) (
  input logic CLK,
  input logic RST_N,
  mem_access_controller_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t           state;
  logic [2:0]       op_q;
  logic [1:0]       off_q;
  logic [CNT_W-1:0] cnt;

  logic        is_half;
  logic        is_word;
  logic        is_store;
  logic        mis;
  logic [3:0]  mask;
  logic [31:0] wdata;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ld_ext;

  assign bus.Ready = (state == IDLE);

  always_comb begin
    is_half  = bus.Op inside {3'd2, 3'd3, 3'd6};
    is_word  = bus.Op inside {3'd4, 3'd7};
    is_store = bus.Op >= 3'd5;
    mis      = (is_half && bus.Addr[0]) ||
               (is_word && bus.Addr[1:0] != 2'b00);
    mask  = 4'b1000 >> bus.Addr[1:0];
    wdata = bus.StoreData;
    unique case (1'b1)
      is_word: mask = 4'b1111;
      is_half: mask = bus.Addr[1] ? 4'b0011 : 4'b1100;
      default: ;
    endcase
    unique case (bus.Op)
      3'd5:    wdata = {4{bus.StoreData[7:0]}};
      3'd6:    wdata = {2{bus.StoreData[15:0]}};
      default: ;
    endcase
  end

  // Lane 0 is the most significant byte of the word.
  always_comb begin
    lane_b = '0;
    lane_h = '0;
    ld_ext = bus.MemReadData;
    unique case (off_q)
      2'd0: lane_b = bus.MemReadData[31:24];
      2'd1: lane_b = bus.MemReadData[23:16];
      2'd2: lane_b = bus.MemReadData[15:8];
      2'd3: lane_b = bus.MemReadData[7:0];
    endcase
    lane_h = off_q[1] ? bus.MemReadData[15:0]
                      : bus.MemReadData[31:16];
    unique case (op_q)
      3'd0:    ld_ext = {{24{lane_b[7]}}, lane_b};
      3'd1:    ld_ext = {24'd0, lane_b};
      3'd2:    ld_ext = {{16{lane_h[15]}}, lane_h};
      3'd3:    ld_ext = {16'd0, lane_h};
      default: ld_ext = bus.MemReadData;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state              <= IDLE;
      op_q               <= '0;
      off_q              <= '0;
      cnt                <= '0;
      bus.Done           <= 1'b0;
      bus.AddrError      <= 1'b0;
      bus.BusError       <= 1'b0;
      bus.LoadData       <= '0;
      bus.MemAddress     <= '0;
      bus.MemWriteData   <= '0;
      bus.MemWriteEnable <= 1'b0;
      bus.MemReadEnable  <= 1'b0;
      bus.MemByteEnable  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.Req) begin
            op_q  <= bus.Op;
            off_q <= bus.Addr[1:0];
            if (mis) begin
              bus.AddrError <= 1'b1;
              bus.Done      <= 1'b1;
              state         <= RESP;
            end else begin
              bus.MemAddress     <= {bus.Addr[31:2], 2'b00};
              bus.MemByteEnable  <= mask;
              bus.MemWriteData   <= wdata;
              bus.MemWriteEnable <= is_store;
              bus.MemReadEnable  <= !is_store;
              state              <= ACCESS;
            end
          end
        end
        ACCESS: begin
          cnt <= cnt + 1'b1;
          if (bus.MemAck) begin
            if (bus.MemReadEnable)
              bus.LoadData <= ld_ext;
            bus.MemWriteEnable <= 1'b0;
            bus.MemReadEnable  <= 1'b0;
            bus.Done           <= 1'b1;
            state              <= RESP;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            bus.MemWriteEnable <= 1'b0;
            bus.MemReadEnable  <= 1'b0;
            bus.BusError       <= 1'b1;
            bus.Done           <= 1'b1;
            state              <= RESP;
          end
        end
        RESP: begin
          bus.Done      <= 1'b0;
          bus.AddrError <= 1'b0;
          bus.BusError  <= 1'b0;
          cnt           <= '0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_controller.sv
// Bench for mem_access_controller: transaction-level reference
// model, a memory responder and per-cycle output comparison.
module tb_mem_access_controller;
  localparam int TIMEOUT = 8;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  mem_access_controller_if bus ();

  mem_access_controller #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (4)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: ack one cycle after the enable is seen.
  logic [31:0] mem_rsp [64];
  bit          ack_off = 1'b0;
  int          en_total = 0;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bus.MemAck   <= 1'b0;
      mem_rsp[4]   <= 32'h1280_3456;
      mem_rsp[8]   <= 32'hCAFE_1234;
      mem_rsp[12]  <= 32'h0;
      mem_rsp[16]  <= 32'h0BAD_F00D;
    end else begin
      bus.MemAck <= !ack_off && !bus.MemAck &&
                    (bus.MemReadEnable || bus.MemWriteEnable);
      if (bus.MemReadEnable || bus.MemWriteEnable)
        en_total <= en_total + 1;
      if (bus.MemWriteEnable)
        for (int i = 0; i < 4; i++)
          if (bus.MemByteEnable[i])
            mem_rsp[bus.MemAddress[7:2]][8*i+:8]
              <= bus.MemWriteData[8*i+:8];
    end
  end

  always_comb begin
    bus.MemReadData = 32'h0;
    if (bus.MemReadEnable)
      bus.MemReadData = mem_rsp[bus.MemAddress[7:2]];
  end

  // Reference model: one transaction at a time.
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] ldv;
    bit          st;
    bit          aerr;
    bit          berr;
    bit          upd;
    int          en_last;
    int          len;
  } exp_t;

  function automatic exp_t predict(input logic [2:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] sd,
                                   input logic [31:0] word,
                                   input bit noack);
    exp_t e;
    int size, off;
    logic [31:0] v;
    size = (op inside {3'd0, 3'd1, 3'd5}) ? 1 :
           (op inside {3'd2, 3'd3, 3'd6}) ? 2 : 4;
    off    = int'(a[1:0]);
    e.st   = op >= 3'd5;
    e.aerr = (off % size) != 0;
    e.berr = !e.aerr && noack;
    e.addr = a & 32'hFFFF_FFFC;
    e.mask = '0;
    e.wdata = '0;
    v = '0;
    for (int b = 0; b < 4; b++) begin
      if (b >= off && b < off + size) begin
        e.mask[3-b] = 1'b1;
        v = (v << 8) | 32'(word[8*(3-b)+:8]);
      end
      e.wdata[8*(3-b)+:8] = sd[8*(size-1-(b % size))+:8];
    end
    if ((op == 3'd0 || op == 3'd2) && v[8*size-1])
      v = v - (32'd1 << (8 * size));
    e.ldv     = v;
    e.upd     = !e.st && !e.aerr && !noack;
    e.len     = e.aerr ? 1 : noack ? TIMEOUT + 1 : 3;
    e.en_last = e.aerr ? 0 : noack ? TIMEOUT : 2;
    return e;
  endfunction

  logic [31:0] mdl [64];
  bit          m_busy;
  int          m_cyc;
  exp_t        m_e;
  exp_t        nx;
  logic [31:0] m_load;
  int          cyc = 0;
  int          last_acc = 0;
  int          prev_acc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_busy  <= 1'b0;
      m_cyc   <= 0;
      m_load  <= '0;
      mdl[4]  <= 32'h1280_3456;
      mdl[8]  <= 32'hCAFE_1234;
      mdl[12] <= 32'h0;
      mdl[16] <= 32'h0BAD_F00D;
    end else if (!m_busy) begin
      if (bus.Req) begin
        nx = predict(bus.Op, bus.Addr, bus.StoreData,
                     mdl[bus.Addr[7:2]], ack_off);
        m_e      <= nx;
        m_busy   <= 1'b1;
        m_cyc    <= 1;
        prev_acc <= last_acc;
        last_acc <= cyc;
        if (nx.st && !nx.aerr)
          for (int i = 0; i < 4; i++)
            if (nx.mask[i])
              mdl[bus.Addr[7:2]][8*i+:8] <= nx.wdata[8*i+:8];
      end
    end else if (m_cyc == m_e.len) begin
      m_busy <= 1'b0;
      if (m_e.upd) m_load <= m_e.ldv;
    end else begin
      m_cyc <= m_cyc + 1;
    end
  end

  bit checking = 1'b0;
  bit c_en, c_dn;

  always @(negedge CLK) begin
    if (RST_N && checking) begin
      c_en = m_busy && !m_e.aerr && m_cyc <= m_e.en_last;
      c_dn = m_busy && m_cyc == m_e.len;
      chk("ready", 32'(bus.Ready), 32'(!m_busy));
      chk("rd_en", 32'(bus.MemReadEnable), 32'(c_en && !m_e.st));
      chk("wr_en", 32'(bus.MemWriteEnable), 32'(c_en && m_e.st));
      chk("done", 32'(bus.Done), 32'(c_dn));
      if (c_en) begin
        chk("mem_addr", bus.MemAddress, m_e.addr);
        chk("byte_en", 32'(bus.MemByteEnable), 32'(m_e.mask));
        if (m_e.st) chk("wdata", bus.MemWriteData, m_e.wdata);
      end
      if (c_dn) begin
        chk("addr_err", 32'(bus.AddrError), 32'(m_e.aerr));
        chk("bus_err", 32'(bus.BusError), 32'(m_e.berr));
      end
      chk("load_data", bus.LoadData,
          (c_dn && m_e.upd) ? m_e.ldv : m_load);
    end
  end

  task automatic issue(input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] sd,
                       input bit keep);
    int n = 0;
    @(negedge CLK);
    bus.Req = 1'b1;
    bus.Op = op;
    bus.Addr = a;
    bus.StoreData = sd;
    while (m_busy && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (m_busy) begin
      tests++;
      fails++;
      $display("FAIL accept_wait: still busy after %0d cycles", n);
    end
    @(posedge CLK);
    #1;
    if (!keep) bus.Req = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge CLK);
    while (m_busy && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (m_busy) begin
      tests++;
      fails++;
      $display("FAIL idle_wait: still busy after %0d cycles", n);
    end
  endtask

  int e0;

  initial begin
    bus.Req = 1'b0;
    bus.Op = '0;
    bus.Addr = '0;
    bus.StoreData = '0;
    RST_N = 1'b1;
    #1 RST_N = 1'b0;
    #2;
    chk("rst_ready", 32'(bus.Ready), 32'd1);
    chk("rst_done", 32'(bus.Done), 32'd0);
    chk("rst_aerr", 32'(bus.AddrError), 32'd0);
    chk("rst_berr", 32'(bus.BusError), 32'd0);
    chk("rst_we", 32'(bus.MemWriteEnable), 32'd0);
    chk("rst_re", 32'(bus.MemReadEnable), 32'd0);
    chk("rst_be", 32'(bus.MemByteEnable), 32'd0);
    chk("rst_ld", bus.LoadData, 32'd0);
    chk("rst_maddr", bus.MemAddress, 32'd0);
    chk("rst_wdata", bus.MemWriteData, 32'd0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    checking = 1'b1;

    issue(3'd0, 32'h11, 32'h0, 1'b0);
    chk("lb_mask", 32'(bus.MemByteEnable), 32'h4);
    chk("lb_addr", bus.MemAddress, 32'h10);
    wait_idle();
    chk("lb_data", bus.LoadData, 32'hFFFF_FF80);

    issue(3'd1, 32'h11, 32'h0, 1'b0);
    wait_idle();
    chk("lbu_data", bus.LoadData, 32'h0000_0080);

    issue(3'd2, 32'h12, 32'h0, 1'b0);
    wait_idle();
    chk("lh_data", bus.LoadData, 32'h0000_3456);

    issue(3'd6, 32'h22, 32'h0000_BEEF, 1'b0);
    chk("sh_mask", 32'(bus.MemByteEnable), 32'h3);
    chk("sh_wdata", bus.MemWriteData, 32'hBEEF_BEEF);
    wait_idle();
    issue(3'd4, 32'h20, 32'h0, 1'b0);
    wait_idle();
    chk("lw_after_sh", bus.LoadData, 32'hCAFE_BEEF);

    e0 = en_total;
    issue(3'd4, 32'h06, 32'h0, 1'b0);
    chk("mis_done", 32'(bus.Done), 32'd1);
    chk("mis_aerr", 32'(bus.AddrError), 32'd1);
    wait_idle();
    chk("mis_strobes", 32'(en_total - e0), 32'd0);
    chk("mis_ld_hold", bus.LoadData, 32'hCAFE_BEEF);

    ack_off = 1'b1;
    e0 = en_total;
    issue(3'd4, 32'h40, 32'h0, 1'b0);
    wait_idle();
    chk("to_en_cycles", 32'(en_total - e0), 32'd8);
    chk("to_ld_hold", bus.LoadData, 32'hCAFE_BEEF);
    ack_off = 1'b0;

    issue(3'd7, 32'h30, 32'hDEAD_BEEF, 1'b1);
    issue(3'd4, 32'h30, 32'h0, 1'b0);
    wait_idle();
    chk("b2b_spacing", 32'(last_acc - prev_acc), 32'd4);
    chk("b2b_lw", bus.LoadData, 32'hDEAD_BEEF);

    issue(3'd5, 32'h33, 32'h0000_00A5, 1'b0);
    chk("sb_mask", 32'(bus.MemByteEnable), 32'h1);
    chk("sb_wdata", bus.MemWriteData, 32'hA5A5_A5A5);
    wait_idle();
    issue(3'd1, 32'h33, 32'h0, 1'b0);
    wait_idle();
    chk("lbu_after_sb", bus.LoadData, 32'h0000_00A5);

    issue(3'd4, 32'h10, 32'h0, 1'b0);
    chk("pre_rst_re", 32'(bus.MemReadEnable), 32'd1);
    #2 RST_N = 1'b0;
    #1;
    chk("mid_rst_re", 32'(bus.MemReadEnable), 32'd0);
    chk("mid_rst_ready", 32'(bus.Ready), 32'd1);
    chk("mid_rst_done", 32'(bus.Done), 32'd0);
    chk("mid_rst_ld", bus.LoadData, 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (6) @(negedge CLK);
    issue(3'd4, 32'h10, 32'h0, 1'b0);
    wait_idle();
    chk("post_rst_lw", bus.LoadData, 32'h1280_3456);

    repeat (2) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_controller.md
Name: mem_access_controller

Overview:
- Sequences every MEM-stage load/store onto the shared word-wide data memory port.
- Generates the word-aligned address, the big-endian ByteEnable mask and the lane-replicated store data.
- Holds the memory enable until the memory Ack arrives, then extracts and sign- or zero-extends load data.
- Reports alignment faults and bus timeouts to the pipeline, which stalls while the controller is not Ready.

Parameters:
- TIMEOUT, 8: cycles in ACCESS without Ack before BusError is reported; minimum 2.
- CNT_W, 4: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- Req  input  1  pipeline access request.
- Op  input  3  0=LB 1=LBU 2=LH 3=LHU 4=LW 5=SB 6=SH 7=SW.
- Addr  input  32  byte address.
- StoreData  input  32  store value, right-justified.
- Ready  output  1  controller idle; a request is accepted when Req&&Ready.
- Done  output  1  one-cycle completion pulse.
- LoadData  output  32  extended load result.
- AddrError  output  1  misaligned access, valid with Done.
- BusError  output  1  timeout, valid with Done.
- MemAddress  output  32  {Addr[31:2],2'b00}.
- MemWriteData  output  32  lane-replicated store data.
- MemWriteEnable  output  1  memory write strobe.
- MemReadEnable  output  1  memory read strobe.
- MemByteEnable  output  4  byte-lane mask; bit3 = bits[31:24].
- MemAck  input  1  memory ack, one cycle after the enable is sampled.
- MemReadData  input  32  memory read word, valid while MemReadEnable is high.

Behaviour:
- One clock; reset is asynchronous and active-low. Clock port is CLK, reset port is RST_N.
- Reset values:
  - State IDLE; Ready=1.
  - Done, AddrError, BusError, MemWriteEnable, MemReadEnable = 0.
  - MemByteEnable=0, LoadData=0, MemAddress=0, MemWriteData=0, timeout counter=0.
- All outputs are registered, except Ready, which decodes the state.
- States: IDLE, ACCESS, RESP.
- IDLE, on Req&&Ready: latch Op, Addr and StoreData.
  - Misaligned means halfword with Addr[0]=1, or word with Addr[1:0]!=0.
  - Misaligned: go to RESP with AddrError=1. No memory strobe is issued.
  - Aligned: go to ACCESS. Drive MemAddress and the lane mask, and assert the read or write enable.
- Lane mask, big-endian, offset = Addr[1:0]:
  - Byte: 1000>>offset.
  - Half: offset 0 gives 1100; offset 2 gives 0011.
  - Word: 1111.
  - Loads use the same mask.
- MemWriteData: SB gives {4{StoreData[7:0]}}; SH gives {2{StoreData[15:0]}}; SW gives StoreData.
- ACCESS: hold the enable and mask until MemAck=1 is sampled, and increment the counter each cycle.
  - On MemAck=1 with a load: capture the selected lane of MemReadData that same cycle. Sign-extend for LB/LH, zero-extend for LBU/LHU; LW takes the full word. Drop the enable, go to RESP.
  - On MemAck=1 with a store: drop the enable, go to RESP. A second write of identical data while the enable is held is harmless.
  - If the counter reaches TIMEOUT-1 without MemAck: drop the enable, set BusError=1, go to RESP. LoadData is unchanged.
- RESP: Done=1 for exactly one cycle, with the error flags valid. Next state IDLE; the counter and flags clear on leaving.
  - Req is ignored in ACCESS and RESP (Ready=0).
- LoadData holds its value until the next successful load completes. Stores and errors do not alter it.
- Latency: accept edge E0, enable high in cycle 1, MemAck in cycle 2, Done in cycle 3, Ready again in cycle 4. Throughput is one access per 4 cycles.
- A late MemAck arriving in IDLE or RESP is ignored.
- Reset asserted mid-operation: all strobes drop immediately. The access is abandoned and Done is not produced.

Test Plan:
- LB at Addr=0x11, memory word 0x12_80_34_56 -> MemByteEnable=0100, MemAddress=0x10, Done in cycle 3, LoadData=0xFFFFFF80. The same with LBU -> 0x00000080.
- SH at Addr=0x22, StoreData=0x0000BEEF -> MemByteEnable=0011, MemWriteData=0xBEEFBEEF; a following LW of 0x20 returns the upper half unchanged and the low half =0xBEEF.
- LW at Addr=0x06 -> no memory strobe in any cycle, Done with AddrError=1 one cycle after accept, LoadData unchanged.
- MemAck tied low with TIMEOUT=8 -> enable high for exactly 8 cycles, then Done with BusError=1, then Ready=1.
- Req held high across back-to-back SW then LW -> second request accepted only when Ready=1 (4-cycle spacing), and the LW returns the stored word.
- RST_N pulsed low during ACCESS -> MemReadEnable low asynchronously, no Done, Ready=1 after release.
